// File: rtl/gravador_sequencia.sv
// Sequence recorder: writes one switch value per accepted button press into the
// external 16x4 sequence memory, addresses 0 upward, until N entries are stored.
module gravador_sequencia #(
    parameter int unsigned N = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       gravar,
    input  logic       jogada,
    input  logic [3:0] chaves,
    output logic       mem_we,
    output logic [3:0] mem_endereco,
    output logic [3:0] mem_dado,
    output logic       gravando,
    output logic       pronto,
    output logic [3:0] db_endereco,
    output logic [3:0] db_dado,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        Inicial    = 4'h0,
        Preparacao = 4'h1,
        Espera     = 4'h2,
        Registra   = 4'h3,
        Escreve    = 4'h4,
        Proximo    = 4'h5,
        Fim        = 4'hF
    } estado_t;

    estado_t    estado;
    logic [3:0] contador;
    logic [3:0] dado;
    logic       jogada_d;
    logic       pendente;
    logic       borda;
    logic       borda_valida;
    logic       fim_c;

    assign borda        = jogada & ~jogada_d;
    assign borda_valida = borda & (chaves != 4'd0);
    assign fim_c        = (contador == 4'(N - 1));

    // An edge is latched into pendente only on edges that leave the FSM in espera, so
    // edges seen in any other state are dropped rather than queued.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado   <= Inicial;
            contador <= 4'd0;
            dado     <= 4'd0;
            jogada_d <= 1'b0;
            pendente <= 1'b0;
            mem_we   <= 1'b0;
            gravando <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            jogada_d <= jogada;
            pendente <= 1'b0;
            mem_we   <= 1'b0;
            case (estado)
                Inicial: begin
                    if (gravar) begin
                        estado   <= Preparacao;
                        gravando <= 1'b1;
                    end
                end
                Preparacao: begin
                    contador <= 4'd0;
                    dado     <= 4'd0;
                    estado   <= Espera;
                    pendente <= borda_valida;
                end
                Espera: begin
                    if (pendente) begin
                        dado   <= chaves;
                        estado <= Registra;
                    end else begin
                        pendente <= borda_valida;
                    end
                end
                Registra: begin
                    estado <= Escreve;
                    mem_we <= 1'b1;
                end
                Escreve: begin
                    estado <= Proximo;
                end
                Proximo: begin
                    if (fim_c) begin
                        estado   <= Fim;
                        gravando <= 1'b0;
                        pronto   <= 1'b1;
                    end else begin
                        contador <= contador + 4'd1;
                        estado   <= Espera;
                        pendente <= borda_valida;
                    end
                end
                Fim: begin
                    if (gravar) begin
                        estado   <= Preparacao;
                        gravando <= 1'b1;
                        pronto   <= 1'b0;
                    end
                end
                default: begin
                    estado   <= Inicial;
                    gravando <= 1'b0;
                    pronto   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_endereco = contador;
    assign mem_dado     = dado;
    assign db_endereco  = contador;
    assign db_dado      = dado;
    assign db_estado    = estado;

endmodule

// File: tb/tb_gravador_sequencia.sv
// Bench for gravador_sequencia: an N=16 and an N=3 instance, checked against a
// list-of-writes model of a recording session.
module tb_gravador_sequencia;

    logic       clock = 1'b0;
    logic       reset_a, reset_b;
    logic       gravar, jogada;
    logic [3:0] chaves;

    logic       we_a, grav_a, pronto_a;
    logic [3:0] addr_a, dado_a, dbe_a, dbd_a, est_a;
    logic       we_b, grav_b, pronto_b;
    logic [3:0] addr_b, dado_b, dbe_b, dbd_b, est_b;

    always #5 clock = ~clock;

    gravador_sequencia #(.N(16)) dut_a (
        .clock(clock), .reset(reset_a), .gravar(gravar), .jogada(jogada), .chaves(chaves),
        .mem_we(we_a), .mem_endereco(addr_a), .mem_dado(dado_a), .gravando(grav_a),
        .pronto(pronto_a), .db_endereco(dbe_a), .db_dado(dbd_a), .db_estado(est_a)
    );

    gravador_sequencia #(.N(3)) dut_b (
        .clock(clock), .reset(reset_b), .gravar(gravar), .jogada(jogada), .chaves(chaves),
        .mem_we(we_b), .mem_endereco(addr_b), .mem_dado(dado_b), .gravando(grav_b),
        .pronto(pronto_b), .db_endereco(dbe_b), .db_dado(dbd_b), .db_estado(est_b)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];

    // Session model: every nonzero press while recording becomes the next write.
    bit m_active = 1'b0;
    int m_cnt    = 0;
    int m_n      = 0;

    always @(negedge clock) begin
        if (reset_a && we_a) obs_q.push_back({addr_a, dado_a});
        if (reset_b && we_b) obs_q.push_back({addr_b, dado_b});
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic m_start(input int n);
        m_active = 1'b1;
        m_cnt    = 0;
        m_n      = n;
    endtask

    task automatic m_accept(input logic [3:0] v);
        if (m_active && v != 4'd0) begin
            exp_q.push_back({4'(m_cnt), v});
            m_cnt++;
            if (m_cnt == m_n) m_active = 1'b0;
        end
    endtask

    task automatic compare_writes(input string tag);
        check($sformatf("%s_count", tag), 8'(obs_q.size()), 8'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_entry(input logic [3:0] v);
        chaves = v;
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        repeat (5) tick();
        m_accept(v);
    endtask

    task automatic start_session(input int n);
        gravar = 1'b1;
        tick();
        gravar = 1'b0;
        tick();
        m_start(n);
    endtask

    initial begin
        logic [3:0] v;
        reset_a = 1'b0;
        reset_b = 1'b0;
        gravar  = 1'b0;
        jogada  = 1'b0;
        chaves  = 4'd0;
        repeat (2) tick();

        // Reset from a mid-session state
        reset_a = 1'b1;
        gravar  = 1'b1;
        repeat (3) tick();
        gravar  = 1'b0;
        reset_a = 1'b0;
        repeat (2) tick();
        check("rst_estado", 8'(est_a), 8'h0);
        check("rst_endereco", 8'(dbe_a), 8'h0);
        check("rst_dado", 8'(dbd_a), 8'h0);
        check("rst_we", 8'(we_a), 8'h0);
        check("rst_pronto", 8'(pronto_a), 8'h0);
        check("rst_gravando", 8'(grav_a), 8'h0);
        reset_a = 1'b1;
        obs_q.delete();

        // Start latency
        gravar = 1'b1;
        tick();
        gravar = 1'b0;
        check("start_estado1", 8'(est_a), 8'h1);
        check("start_gravando", 8'(grav_a), 8'h1);
        tick();
        check("start_estado2", 8'(est_a), 8'h2);
        check("start_endereco", 8'(dbe_a), 8'h0);
        m_start(16);

        // Full session with a walking-one pattern
        for (int i = 0; i < 16; i++) do_entry(4'(1 << (i % 4)));
        compare_writes("full16");
        check("full16_pronto", 8'(pronto_a), 8'h1);
        check("full16_estado", 8'(est_a), 8'hF);
        check("full16_endereco", 8'(dbe_a), 8'(m_cnt - 1));
        check("full16_gravando", 8'(grav_a), 8'h0);

        // Cycle-accurate single entry
        start_session(16);
        chaves = 4'd4;
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        check("cyc_t0_we", 8'(we_a), 8'h0);
        tick();
        check("cyc_t1_we", 8'(we_a), 8'h0);
        check("cyc_t1_dado", 8'(dbd_a), 8'h4);
        tick();
        check("cyc_t2_we", 8'(we_a), 8'h1);
        check("cyc_t2_addr_data", {addr_a, dado_a}, 8'h04);
        tick();
        check("cyc_t3_we", 8'(we_a), 8'h0);
        tick();
        check("cyc_t4_estado", 8'(est_a), 8'h2);
        check("cyc_t4_endereco", 8'(dbe_a), 8'h1);
        m_accept(4'd4);
        compare_writes("cyc");

        // Held button gives one entry
        v = 4'($urandom_range(1, 15));
        chaves = v;
        jogada = 1'b1;
        repeat (20) tick();
        jogada = 1'b0;
        repeat (5) tick();
        m_accept(v);
        compare_writes("held");

        // Zero switches are ignored
        do_entry(4'd0);
        check("zero_estado", 8'(est_a), 8'h2);
        compare_writes("zero");

        // Press during escreve is dropped
        v = 4'($urandom_range(1, 15));
        chaves = v;
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        tick();
        tick();
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        repeat (6) tick();
        m_accept(v);
        compare_writes("drop");
        check("drop_endereco", 8'(dbe_a), 8'(m_cnt));

        // Two more random entries, then reset mid-session
        for (int i = 0; i < 2; i++) do_entry(4'($urandom_range(1, 15)));
        compare_writes("pre_rst");
        reset_a = 1'b0;
        repeat (2) tick();
        m_active = 1'b0;
        check("midrst_endereco", 8'(dbe_a), 8'h0);
        check("midrst_estado", 8'(est_a), 8'h0);
        reset_a = 1'b1;
        start_session(16);
        for (int i = 0; i < 16; i++) do_entry(4'($urandom_range(1, 15)));
        compare_writes("rerun16");
        check("rerun16_pronto", 8'(pronto_a), 8'h1);
        check("rerun16_estado", 8'(est_a), 8'hF);

        // Press in fim is ignored
        do_entry(4'($urandom_range(1, 15)));
        compare_writes("fim_press");
        check("fim_press_estado", 8'(est_a), 8'hF);

        // N=3 instance
        reset_a = 1'b0;
        reset_b = 1'b1;
        tick();
        start_session(3);
        for (int i = 0; i < 3; i++) do_entry(4'($urandom_range(1, 15)));
        compare_writes("n3");
        check("n3_pronto", 8'(pronto_b), 8'h1);
        check("n3_endereco", 8'(dbe_b), 8'h2);
        gravar = 1'b1;
        tick();
        gravar = 1'b0;
        check("n3_restart_estado1", 8'(est_b), 8'h1);
        tick();
        check("n3_restart_estado2", 8'(est_b), 8'h2);
        check("n3_restart_endereco", 8'(dbe_b), 8'h0);
        m_start(3);
        for (int i = 0; i < 3; i++) do_entry(4'($urandom_range(0, 15)));
        while (m_active) do_entry(4'($urandom_range(1, 15)));
        compare_writes("n3_second");
        check("n3_second_pronto", 8'(pronto_b), 8'h1);

        // Simultaneous gravar and jogada in fim
        gravar = 1'b1;
        jogada = 1'b1;
        chaves = 4'd7;
        tick();
        gravar = 1'b0;
        jogada = 1'b0;
        check("n3_simul_estado1", 8'(est_b), 8'h1);
        tick();
        check("n3_simul_estado2", 8'(est_b), 8'h2);
        check("n3_simul_endereco", 8'(dbe_b), 8'h0);
        m_start(3);
        repeat (6) tick();
        compare_writes("n3_simul");
        check("n3_simul_estado_after", 8'(est_b), 8'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
